// File: rtl/mem_pkg.sv
// Shared types and widths for the memory responder and its word storage.
package mem_pkg;

  typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_RESP} mem_state_t;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned LAT_W  = 4;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU control path and mem_responder.
// ByteEn is present only when MEM_STRB_EN is defined.
interface mem_responder_if #(
  parameter int unsigned ADDR_W = 32
);
  import mem_pkg::*;

  logic              Req;
  logic              Wr;
  logic [ADDR_W-1:0] Addr;
  logic [WORD_W-1:0] WData;
`ifdef MEM_STRB_EN
  logic [STRB_W-1:0] ByteEn;
`endif
  logic              Ready;
  logic [WORD_W-1:0] RData;
  logic              Err;
  logic              Busy;

`ifdef MEM_STRB_EN
  modport master (output Req, Wr, Addr, WData, ByteEn, input Ready, RData, Err, Busy);
  modport slave  (input Req, Wr, Addr, WData, ByteEn, output Ready, RData, Err, Busy);
`else
  modport master (output Req, Wr, Addr, WData, input Ready, RData, Err, Busy);
  modport slave  (input Req, Wr, Addr, WData, output Ready, RData, Err, Busy);
`endif

endinterface

// File: rtl/mem_word_array.sv
// Word storage: byte-strobed synchronous write, registered read with enable.
// Storage itself is never reset; only the read register is.
module mem_word_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDX_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              we,
  input  logic              re,
  input  logic [STRB_W-1:0] strb,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (strb[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Holds the last completed read until the next one.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one word access per request, LATENCY wait cycles, then a Ready pulse.
// Define MEM_STRB_EN to add per-byte write enables (ByteEn) on the bus.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = 32
) (
  input logic            Clk,
  input logic            Reset,
  mem_responder_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_state_t        state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              fire;
  logic [STRB_W-1:0] bus_strb;
  logic              cur_wr;
  logic [ADDR_W-1:0] cur_addr;
  logic [WORD_W-1:0] cur_wdata;
  logic [STRB_W-1:0] cur_strb;
  logic [ADDR_W-1:0] cur_word;
  logic              cur_ok;

`ifdef MEM_STRB_EN
  assign bus_strb = bus.ByteEn;
`else
  assign bus_strb = '1;
`endif

  assign accept = (state_q == MEM_IDLE) && bus.Req;

  // With LATENCY=0 the access completes on the accept edge, so the bus feeds storage directly.
  assign cur_wr    = (state_q == MEM_IDLE) ? bus.Wr    : wr_q;
  assign cur_addr  = (state_q == MEM_IDLE) ? bus.Addr  : addr_q;
  assign cur_wdata = (state_q == MEM_IDLE) ? bus.WData : wdata_q;
  assign cur_strb  = (state_q == MEM_IDLE) ? bus_strb  : strb_q;

  assign cur_word = cur_addr >> 2;
  assign cur_ok   = (cur_addr[1:0] == 2'b00) && (cur_word < ADDR_W'(DEPTH));

  // Edge that enters RESP: storage write, read load and response flags all happen here.
  assign fire = (accept && (LATENCY == 0)) ||
                ((state_q == MEM_WAIT) && (cnt_q == LAT_W'(1)));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MEM_IDLE: begin
        if (bus.Req) begin
          cnt_d   = LAT_W'(LATENCY);
          state_d = (LATENCY == 0) ? MEM_RESP : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        cnt_d = cnt_q - LAT_W'(1);
        if (cnt_q == LAT_W'(1)) state_d = MEM_RESP;
      end
      MEM_RESP: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  always_comb begin
    ready_d = fire;
    err_d   = fire && !cur_ok;
    busy_d  = (state_d != MEM_IDLE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      if (accept) begin
        wr_q    <= bus.Wr;
        addr_q  <= bus.Addr;
        wdata_q <= bus.WData;
        strb_q  <= bus_strb;
      end
    end
  end

  mem_word_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .Clk   (Clk),
    .Reset (Reset),
    .we    (fire && cur_wr && cur_ok),
    .re    (fire && !cur_wr && cur_ok),
    .strb  (cur_strb),
    .idx   (cur_word[IDX_W-1:0]),
    .wdata (cur_wdata),
    .rdata (bus.RData)
  );

  assign bus.Ready = ready_q;
  assign bus.Err   = err_q;
  assign bus.Busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY 2 and 0) share stimulus and are checked
// against a word-array reference model. Build with MEM_STRB_EN to cover byte enables.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int unsigned Depth = 256;
  localparam int unsigned AddrW = 32;
  localparam int unsigned LatL2 = 2;
  localparam int unsigned LatL0 = 0;
`ifdef MEM_STRB_EN
  localparam bit StrbEn = 1'b1;
`else
  localparam bit StrbEn = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
`ifdef MEM_STRB_EN
  logic [3:0]  byte_en = 4'hF;
`endif

  mem_responder_if #(.ADDR_W(AddrW)) bus_l2 ();
  mem_responder_if #(.ADDR_W(AddrW)) bus_l0 ();

  assign bus_l2.Req = req;
  assign bus_l2.Wr = wr;
  assign bus_l2.Addr = addr;
  assign bus_l2.WData = wdata;
  assign bus_l0.Req = req;
  assign bus_l0.Wr = wr;
  assign bus_l0.Addr = addr;
  assign bus_l0.WData = wdata;
`ifdef MEM_STRB_EN
  assign bus_l2.ByteEn = byte_en;
  assign bus_l0.ByteEn = byte_en;
`endif

  mem_responder #(.DEPTH(Depth), .LATENCY(LatL2), .ADDR_W(AddrW)) u_dut_l2 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_l2.slave)
  );

  mem_responder #(.DEPTH(Depth), .LATENCY(LatL0), .ADDR_W(AddrW)) u_dut_l0 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_l0.slave)
  );

  // Index 0 = LATENCY 2 instance, index 1 = LATENCY 0 instance.
  logic [1:0]  o_ready, o_err, o_busy;
  logic [31:0] o_rdata [2];
  assign o_ready = {bus_l0.Ready, bus_l2.Ready};
  assign o_err = {bus_l0.Err, bus_l2.Err};
  assign o_busy = {bus_l0.Busy, bus_l2.Busy};
  assign o_rdata[0] = bus_l2.RData;
  assign o_rdata[1] = bus_l0.RData;

  // Reference model: stored words and last read result per instance.
  logic [31:0] mem_m [2][Depth];
  logic [31:0] rd_m [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned lat_of(input int k);
    return (k == 0) ? LatL2 : LatL0;
  endfunction

  // One request; bus inputs are scrambled while the access is in flight.
  task automatic run_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be);
    logic [7:0]  rdy_mask [2];
    logic [7:0]  busy_mask [2];
    logic [31:0] rd_at [2];
    logic        err_at [2];
    logic        ok;
    logic [3:0]  lanes;
    int unsigned idx;
    ok = (a[1:0] == 2'b00) && ((a >> 2) < Depth);
    idx = a >> 2;
    lanes = StrbEn ? be : 4'hF;
    for (int k = 0; k < 2; k++) begin
      rdy_mask[k] = '0;
      busy_mask[k] = '0;
      rd_at[k] = 'x;
      err_at[k] = 1'bx;
    end
    @(negedge Clk);
    req = 1'b1;
    wr = w;
    addr = a;
    wdata = d;
`ifdef MEM_STRB_EN
    byte_en = be;
`endif
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clk);
      req = 1'b0;
      wr = 1'($urandom);
      addr = $urandom;
      wdata = $urandom;
`ifdef MEM_STRB_EN
      byte_en = 4'($urandom);
`endif
      for (int k = 0; k < 2; k++) begin
        busy_mask[k][c-1] = o_busy[k];
        if (o_ready[k]) begin
          rdy_mask[k][c-1] = 1'b1;
          rd_at[k] = o_rdata[k];
          err_at[k] = o_err[k];
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (ok && w) begin
        for (int b = 0; b < 4; b++) begin
          if (lanes[b]) mem_m[k][idx][b*8 +: 8] = d[b*8 +: 8];
        end
      end
      if (ok && !w) rd_m[k] = mem_m[k][idx];
      check_val($sformatf("ready_cycle[L%0d a=%h]", lat_of(k), a), 32'(rdy_mask[k]),
                32'(1) << lat_of(k));
      check_val($sformatf("busy_cycles[L%0d a=%h]", lat_of(k), a), 32'(busy_mask[k]),
                (32'(1) << (lat_of(k) + 1)) - 32'(1));
      check_val($sformatf("err[L%0d a=%h]", lat_of(k), a), 32'(err_at[k]), 32'(!ok));
      check_val($sformatf("rdata[L%0d a=%h]", lat_of(k), a), rd_at[k], rd_m[k]);
      check_val($sformatf("rdata_hold[L%0d a=%h]", lat_of(k), a), o_rdata[k], rd_m[k]);
    end
  endtask

  // Req held high for 10 edges; accepts only happen once the previous access has finished.
  task automatic run_burst(input logic [31:0] a);
    logic [15:0] rdy_obs [2];
    logic [15:0] busy_obs [2];
    logic [15:0] rdy_exp [2];
    logic [15:0] busy_exp [2];
    int unsigned next_free;
    int unsigned lat;
    for (int k = 0; k < 2; k++) begin
      rdy_obs[k] = '0;
      busy_obs[k] = '0;
      rdy_exp[k] = '0;
      busy_exp[k] = '0;
      next_free = 0;
      lat = lat_of(k);
      for (int unsigned e = 0; e < 10; e++) begin
        if (e >= next_free) begin
          rdy_exp[k][e + lat] = 1'b1;
          for (int unsigned c = e + 1; c <= e + lat + 1; c++) busy_exp[k][c-1] = 1'b1;
          next_free = e + lat + 2;
        end
      end
    end
    @(negedge Clk);
    req = 1'b1;
    wr = 1'b0;
    addr = a;
    for (int c = 1; c <= 14; c++) begin
      @(negedge Clk);
      for (int k = 0; k < 2; k++) begin
        rdy_obs[k][c-1] = o_ready[k];
        busy_obs[k][c-1] = o_busy[k];
      end
      if (c == 10) req = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      rd_m[k] = mem_m[k][a >> 2];
      check_val($sformatf("burst_ready[L%0d]", lat_of(k)), 32'(rdy_obs[k]), 32'(rdy_exp[k]));
      check_val($sformatf("burst_busy[L%0d]", lat_of(k)), 32'(busy_obs[k]), 32'(busy_exp[k]));
      check_val($sformatf("burst_rdata[L%0d]", lat_of(k)), o_rdata[k], rd_m[k]);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("%s_ready[L%0d]", tag, lat_of(k)), 32'(o_ready[k]), 32'(0));
      check_val($sformatf("%s_err[L%0d]", tag, lat_of(k)), 32'(o_err[k]), 32'(0));
      check_val($sformatf("%s_busy[L%0d]", tag, lat_of(k)), 32'(o_busy[k]), 32'(0));
      check_val($sformatf("%s_rdata[L%0d]", tag, lat_of(k)), o_rdata[k], 32'(0));
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] rdy_seen;
    int unsigned kind;

    repeat (2) @(negedge Clk);
    check_idle_outputs("reset");
    Reset = 1'b1;
    for (int k = 0; k < 2; k++) rd_m[k] = '0;

    // Give every word a known value.
    for (int unsigned i = 0; i < Depth; i++) run_access(1'b1, 32'(i * 4), $urandom, 4'hF);

    run_access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    run_access(1'b0, 32'h10, 32'h0, 4'hF);
    check_val("read_0x10", o_rdata[0], 32'hDEADBEEF);

    run_access(1'b1, 32'h0, 32'h12345678, 4'hF);
    run_access(1'b0, 32'h0, 32'h0, 4'hF);
    check_val("l0_read_0x0", o_rdata[1], 32'h12345678);

    run_access(1'b1, 32'h6, 32'hCAFEF00D, 4'hF);
    run_access(1'b0, 32'h4, 32'h0, 4'hF);
    run_access(1'b0, 32'(Depth * 4), 32'h0, 4'hF);
    run_access(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF);

    run_burst(32'h10);

    // Reset while the LATENCY 2 write is waiting: it is dropped, no Ready follows.
    @(negedge Clk);
    req = 1'b1;
    wr = 1'b1;
    addr = 32'h20;
    wdata = 32'hAAAAAAAA;
`ifdef MEM_STRB_EN
    byte_en = 4'hF;
`endif
    @(negedge Clk);
    req = 1'b0;
    Reset = 1'b0;
    mem_m[1][8] = 32'hAAAAAAAA;
    for (int k = 0; k < 2; k++) rd_m[k] = '0;
    #1;
    check_idle_outputs("abort");
    @(negedge Clk);
    Reset = 1'b1;
    rdy_seen = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      rdy_seen[c] = o_ready[0];
    end
    check_val("abort_no_ready", rdy_seen, 32'h0);
    run_access(1'b0, 32'h20, 32'h0, 4'hF);

`ifdef MEM_STRB_EN
    run_access(1'b1, 32'h30, 32'hFFFFFFFF, 4'hF);
    run_access(1'b1, 32'h30, 32'h11223344, 4'b0011);
    run_access(1'b0, 32'h30, 32'h0, 4'b0000);
    check_val("strb_read", o_rdata[0], 32'hFFFF3344);
    run_access(1'b1, 32'h30, 32'h55667788, 4'b0000);
    run_access(1'b0, 32'h30, 32'h0, 4'hF);
`endif

    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) a = 32'($urandom_range(0, Depth - 1) * 4 + $urandom_range(1, 3));
      else if (kind == 1) a = 32'(Depth * 4) + ($urandom & 32'h00FF_FFFC);
      else a = 32'($urandom_range(0, 15) * 4);
      run_access(1'($urandom), a, $urandom, 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
